// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (2-byte big-endian word count, then
// big-endian 32-bit words) and writes the words to consecutive instruction
// memory locations. The CPU is held until the whole program is in memory.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W+1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  // Capacity in words, held at 17 bits so a full 16-bit count compares cleanly.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t      state;
  state_t      state_next;
  logic [7:0]  len_hi;
  logic [15:0] word_total;
  logic [31:0] word_reg;
  logic [1:0]  byte_idx;
  logic        transfer;
  logic        start_ok;
  logic [15:0] header_now;
  logic        last_word;

  assign transfer   = byte_valid & byte_ready;
  assign start_ok   = start & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign header_now = {len_hi, byte_data};
  assign last_word  = ((17'(words_written) + 17'd1) == {1'b0, word_total});

  // State register; reset returns to IDLE from anywhere, including mid-load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a load in progress cannot be restarted by start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = LEN_HI;
      LEN_HI: if (transfer) state_next = LEN_LO;
      LEN_LO: begin
        if (transfer) begin
          if (header_now == 16'd0) begin
            state_next = DONE;
          end else if ({1'b0, header_now} > CAPACITY) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA:   if (transfer && byte_idx == 2'd3) state_next = WRITE;
      WRITE:  state_next = last_word ? DONE : DATA;
      DONE:   if (start) state_next = LEN_HI;
      ERR:    if (start) state_next = LEN_HI;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; everything depends on registered state only.
  always_comb begin
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA: byte_ready = 1'b1;
      WRITE:                imem_we    = 1'b1;
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ERR:                  error      = 1'b1;
      default: ;
    endcase
  end

  // Datapath: header capture, byte assembly into the word and write counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi        <= '0;
      word_total    <= '0;
      word_reg      <= '0;
      byte_idx      <= '0;
      words_written <= '0;
    end else if (start_ok) begin
      word_reg      <= '0;
      byte_idx      <= '0;
      words_written <= '0;
    end else begin
      case (state)
        LEN_HI: if (transfer) len_hi <= byte_data;
        LEN_LO: if (transfer) word_total <= header_now;
        DATA: begin
          if (transfer) begin
            word_reg <= {word_reg[23:0], byte_data};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE:  words_written <= words_written + 1'b1;
        default: ;
      endcase
    end
  end

  // Only written while fewer than capacity words are done, so the low bits suffice.
  assign imem_addr  = {words_written[ADDR_W-1:0], 2'b00};
  assign imem_wdata = word_reg;

endmodule
